// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV64 fetch stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Optional IF_PERF_CNT_EN adds stall_cycles/flush_count performance counters.
module if_fetch_stage #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PC_Write,
    input  logic                 IF_ID_Write,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    if_fetch_stage_if.master     imem,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      IF_ID_pc,
    output logic [31:0]          IF_ID_instr,
    output logic                 IF_ID_valid,
    output logic [4:0]           IF_ID_rs1,
    output logic [4:0]           IF_ID_rs2,
    output logic [6:0]           IF_ID_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        stall_s;
    logic        load_s;
    logic        capture_s;
    logic [31:0] load_instr_s;
    logic [31:0] hold_buf_r;

    assign imem.imem_req  = (state_r == S_REQ);
    assign imem.imem_addr = pc;
    assign IF_ID_rs1      = IF_ID_instr[19:15];
    assign IF_ID_rs2      = IF_ID_instr[24:20];
    assign IF_ID_opcode   = IF_ID_instr[6:0];

    // Next-state and IF/ID load decisions; a redirect overrides every other action.
    always_comb begin
        stall_s      = ~PC_Write | ~IF_ID_Write;
        state_s      = state_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        load_instr_s = imem.imem_rdata;
        if (branch_taken) begin
            // A request already accepted must have its response swallowed in S_DROP.
            case (state_r)
                S_REQ:   state_s = imem.imem_ready  ? S_DROP : S_REQ;
                S_WAIT:  state_s = imem.imem_rvalid ? S_REQ  : S_DROP;
                S_HOLD:  state_s = S_REQ;
                S_DROP:  state_s = imem.imem_rvalid ? S_REQ  : S_DROP;
                default: state_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem.imem_ready) state_s = S_WAIT;
                    else                 state_s = S_REQ;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid && stall_s) begin
                        capture_s = 1'b1;
                        state_s   = S_HOLD;
                    end else if (imem.imem_rvalid) begin
                        load_s    = 1'b1;
                        state_s   = S_REQ;
                    end else begin
                        state_s   = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall_s) begin
                        load_s       = 1'b1;
                        load_instr_s = hold_buf_r;
                        state_s      = S_REQ;
                    end else begin
                        state_s      = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rvalid) state_s = S_REQ;
                    else                  state_s = S_DROP;
                end
                default: state_s = S_REQ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_REQ;
        else       state_r <= state_s;
    end

    // PC, IF/ID register and hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            IF_ID_pc    <= {XLEN{1'b0}};
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            hold_buf_r  <= NOP_INSTR;
        end else if (branch_taken) begin
            pc          <= branch_target;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            hold_buf_r  <= NOP_INSTR;
        end else begin
            if (load_s) begin
                IF_ID_pc    <= pc;
                IF_ID_instr <= load_instr_s;
                IF_ID_valid <= 1'b1;
                pc          <= pc + {{(XLEN-3){1'b0}}, 3'd4};
            end
            if (capture_s) hold_buf_r <= imem.imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Free-running stall and flush event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (stall_s)      stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken) flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; instance b uses a near-top RESET_PC to exercise PC wrap.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, PC_Write, IF_ID_Write, branch_taken;
    logic [63:0] branch_target;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    int          checks, failures;

    logic [63:0] pc_a, ifpc_a, pc_b, ifpc_b;
    logic [31:0] instr_a, instr_b;
    logic        valid_a, valid_b;
    logic [4:0]  rs1_a, rs2_a, rs1_b, rs2_b;
    logic [6:0]  op_a, op_b;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

    always #5 clk = ~clk;

    if_fetch_stage_if #(.XLEN(64)) bus_a ();
    if_fetch_stage_if #(.XLEN(64)) bus_b ();

    assign bus_a.imem_ready  = mem_ready;
    assign bus_a.imem_rvalid = mem_rvalid;
    assign bus_a.imem_rdata  = mem_rdata;
    assign bus_b.imem_ready  = mem_ready;
    assign bus_b.imem_rvalid = mem_rvalid;
    assign bus_b.imem_rdata  = mem_rdata;

    if_fetch_stage dut_a (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(bus_a),
        .pc(pc_a), .IF_ID_pc(ifpc_a), .IF_ID_instr(instr_a), .IF_ID_valid(valid_a),
        .IF_ID_rs1(rs1_a), .IF_ID_rs2(rs2_a), .IF_ID_opcode(op_a)
`ifdef IF_PERF_CNT_EN
        , .stall_cycles(stall_a), .flush_count(flush_a)
`endif
    );

    if_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(bus_b),
        .pc(pc_b), .IF_ID_pc(ifpc_b), .IF_ID_instr(instr_b), .IF_ID_valid(valid_b),
        .IF_ID_rs1(rs1_b), .IF_ID_rs2(rs2_b), .IF_ID_opcode(op_b)
`ifdef IF_PERF_CNT_EN
        , .stall_cycles(stall_b), .flush_count(flush_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        reset = 1'b0;
        checks += 7;
        if (pc_a !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_a, 64'h0); end
        if (ifpc_a !== 64'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h exp=%h", ifpc_a, 64'h0); end
        if (instr_a !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_a, 32'h13); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        if (bus_a.imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", bus_a.imem_req); end
        if (bus_a.imem_addr !== 64'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus_a.imem_addr); end
        if (pc_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL reset_pc_b got=%h exp=fffffffffffffffc", pc_b); end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (stall_a !== 32'd0 || flush_a !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_a, flush_a); end
`endif
    endtask

    task automatic test_zero_wait_fetch();
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        checks++;
        if (bus_a.imem_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%b exp=0", bus_a.imem_req); end
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; tick(); mem_rvalid = 1'b0;
        checks += 11;
        if (instr_a !== 32'h0050_0093) begin failures++; $display("FAIL fetch1_instr got=%h exp=00500093", instr_a); end
        if (ifpc_a !== 64'h0) begin failures++; $display("FAIL fetch1_ifid_pc got=%h exp=0", ifpc_a); end
        if (valid_a !== 1'b1) begin failures++; $display("FAIL fetch1_valid got=%b exp=1", valid_a); end
        if (pc_a !== 64'h4) begin failures++; $display("FAIL fetch1_pc got=%h exp=4", pc_a); end
        if (bus_a.imem_addr !== 64'h4) begin failures++; $display("FAIL fetch1_addr got=%h exp=4", bus_a.imem_addr); end
        if (rs1_a !== 5'd0) begin failures++; $display("FAIL fetch1_rs1 got=%0d exp=0", rs1_a); end
        if (rs2_a !== 5'd5) begin failures++; $display("FAIL fetch1_rs2 got=%0d exp=5", rs2_a); end
        if (op_a !== 7'h13) begin failures++; $display("FAIL fetch1_opcode got=%h exp=13", op_a); end
        if (pc_b !== 64'h0) begin failures++; $display("FAIL wrap_pc_b got=%h exp=0", pc_b); end
        if (ifpc_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_ifid_pc_b got=%h exp=fffffffffffffffc", ifpc_b); end
        if (bus_b.imem_addr !== 64'h0) begin failures++; $display("FAIL wrap_addr_b got=%h exp=0", bus_b.imem_addr); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0113; tick(); mem_rvalid = 1'b0;
        checks += 3;
        if (bus_a.imem_addr !== 64'h8) begin failures++; $display("FAIL fetch2_addr got=%h exp=8", bus_a.imem_addr); end
        if (instr_a !== 32'h00A0_0113) begin failures++; $display("FAIL fetch2_instr got=%h exp=00a00113", instr_a); end
        if (rs2_a !== 5'd10) begin failures++; $display("FAIL fetch2_rs2 got=%0d exp=10", rs2_a); end
    endtask

    task automatic test_stall_hold();
        // imem not ready for two cycles: request and address must stay put.
        tick(); tick();
        checks++;
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'h8) begin
            failures++; $display("FAIL req_wait got=%b/%h exp=1/8", bus_a.imem_req, bus_a.imem_addr);
        end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        PC_Write = 1'b0; IF_ID_Write = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0030_8193; tick(); mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (instr_a !== 32'h00A0_0113 || ifpc_a !== 64'h4 || pc_a !== 64'h8 || bus_a.imem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got instr=%h ifpc=%h pc=%h req=%b exp 00a00113/4/8/0", i, instr_a, ifpc_a, pc_a, bus_a.imem_req);
            end
        end
        PC_Write = 1'b1; IF_ID_Write = 1'b1; tick();
        checks += 4;
        if (instr_a !== 32'h0030_8193) begin failures++; $display("FAIL release_instr got=%h exp=00308193", instr_a); end
        if (ifpc_a !== 64'h8) begin failures++; $display("FAIL release_ifid_pc got=%h exp=8", ifpc_a); end
        if (pc_a !== 64'hC) begin failures++; $display("FAIL release_pc got=%h exp=c", pc_a); end
        if (bus_a.imem_req !== 1'b1 || valid_a !== 1'b1) begin failures++; $display("FAIL release_req_valid got=%b/%b exp=1/1", bus_a.imem_req, valid_a); end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (stall_a !== 32'd3) begin failures++; $display("FAIL stall_cycles got=%0d exp=3", stall_a); end
`endif
    endtask

    task automatic test_branch_flush();
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 64'h100; tick(); branch_taken = 1'b0;
        checks += 4;
        if (pc_a !== 64'h100) begin failures++; $display("FAIL flush_pc got=%h exp=100", pc_a); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_a); end
        if (instr_a !== 32'h0000_0013) begin failures++; $display("FAIL flush_instr got=%h exp=13", instr_a); end
        if (bus_a.imem_req !== 1'b0) begin failures++; $display("FAIL flush_drop_req got=%b exp=0", bus_a.imem_req); end
        tick();
        checks++;
        if (bus_a.imem_req !== 1'b0) begin failures++; $display("FAIL drop_pending_req got=%b exp=0", bus_a.imem_req); end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_rvalid = 1'b0;
        checks += 2;
        if (valid_a !== 1'b0 || instr_a !== 32'h0000_0013) begin failures++; $display("FAIL drop_ignored got=%b/%h exp=0/13", valid_a, instr_a); end
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'h100) begin failures++; $display("FAIL redirect_addr got=%b/%h exp=1/100", bus_a.imem_req, bus_a.imem_addr); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0040_0213; tick(); mem_rvalid = 1'b0;
        checks++;
        if (ifpc_a !== 64'h100 || instr_a !== 32'h0040_0213 || pc_a !== 64'h104) begin
            failures++; $display("FAIL target_fetch got=%h/%h/%h exp=100/00400213/104", ifpc_a, instr_a, pc_a);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (flush_a !== 32'd1) begin failures++; $display("FAIL flush_count got=%0d exp=1", flush_a); end
`endif
    endtask

    task automatic test_branch_over_stall();
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        PC_Write = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1113;
        branch_taken = 1'b1; branch_target = 64'h200; tick();
        PC_Write = 1'b1; mem_rvalid = 1'b0; branch_taken = 1'b0;
        checks += 3;
        if (pc_a !== 64'h200) begin failures++; $display("FAIL prio_pc got=%h exp=200", pc_a); end
        if (valid_a !== 1'b0 || instr_a !== 32'h0000_0013) begin failures++; $display("FAIL prio_flush got=%b/%h exp=0/13", valid_a, instr_a); end
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'h200) begin failures++; $display("FAIL prio_req got=%b/%h exp=1/200", bus_a.imem_req, bus_a.imem_addr); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0293; tick(); mem_rvalid = 1'b0;
        checks++;
        if (ifpc_a !== 64'h200 || instr_a !== 32'h0050_0293 || pc_a !== 64'h204) begin
            failures++; $display("FAIL post_prio_fetch got=%h/%h/%h exp=200/00500293/204", ifpc_a, instr_a, pc_a);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (stall_a !== 32'd4 || flush_a !== 32'd2) begin failures++; $display("FAIL prio_cnt got=%0d/%0d exp=4/2", stall_a, flush_a); end
`endif
    endtask

    task automatic test_reset_mid_request();
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0013; tick(); mem_rvalid = 1'b0;
        checks += 3;
        if (valid_a !== 1'b0 || instr_a !== 32'h0000_0013) begin failures++; $display("FAIL stale_ignored got=%b/%h exp=0/13", valid_a, instr_a); end
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 64'h0) begin failures++; $display("FAIL rst_addr got=%b/%h exp=1/0", bus_a.imem_req, bus_a.imem_addr); end
        if (pc_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL rst_pc_b got=%h exp=fffffffffffffffc", pc_b); end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (stall_a !== 32'd0 || flush_a !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_a, flush_a); end
`endif
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0070_0393; tick(); mem_rvalid = 1'b0;
        checks += 2;
        if (ifpc_a !== 64'h0 || instr_a !== 32'h0070_0393 || pc_a !== 64'h4) begin
            failures++; $display("FAIL recover_fetch got=%h/%h/%h exp=0/00700393/4", ifpc_a, instr_a, pc_a);
        end
        if (pc_b !== 64'h0 || valid_b !== 1'b1 || instr_b !== 32'h0070_0393) begin
            failures++; $display("FAIL recover_wrap_b got=%h/%b/%h exp=0/1/00700393", pc_b, valid_b, instr_b);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; PC_Write = 1'b1; IF_ID_Write = 1'b1;
        branch_taken = 1'b0; branch_target = 64'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_zero_wait_fetch();
        test_stall_hold();
        test_branch_flush();
        test_branch_over_stall();
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
